tmds_sequencer: RTL



---
 rtl/tmds_sequencer_if.sv | 30 +++
 rtl/tmds_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/tmds_sequencer_if.sv
// tmds_sequencer_if: pixel-source, encoder and serializer signals of the TMDS sequencer.
// The master modport is the sequencer's view; slave is the surrounding system's view.
interface tmds_sequencer_if;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        pix_rdy;
    logic [10:0] x;
    logic [10:0] y;
    logic        frame_start;
    logic [7:0]  enc_din0;
    logic [7:0]  enc_din1;
    logic [7:0]  enc_din2;
    logic [9:0]  enc_q0;
    logic [9:0]  enc_q1;
    logic [9:0]  enc_q2;
    logic [9:0]  tmds0;
    logic [9:0]  tmds1;
    logic [9:0]  tmds2;

    modport master (
        input  pix_r, pix_g, pix_b, enc_q0, enc_q1, enc_q2,
        output pix_rdy, x, y, frame_start, enc_din0, enc_din1, enc_din2, tmds0, tmds1, tmds2
    );

    modport slave (
        output pix_r, pix_g, pix_b, enc_q0, enc_q1, enc_q2,
        input  pix_rdy, x, y, frame_start, enc_din0, enc_din1, enc_din2, tmds0, tmds1, tmds2
    );
endinterface

// File: rtl/tmds_sequencer.sv
// tmds_sequencer: raster timing and per-channel symbol scheduling in front of three TMDS encoders.
// Define TMDS_SEQ_HDMI_GUARD_EN to insert the HDMI video preamble and leading guard band.
module tmds_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    tmds_sequencer_if.master  bus
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  CTL_00   = 10'b1101010100;
    localparam logic [9:0]  CTL_01   = 10'b0010101011;
    localparam logic [9:0]  CTL_10   = 10'b0101010100;
    localparam logic [9:0]  CTL_11   = 10'b1010101011;
    localparam logic [9:0]  BLANK0   = SYNC_POL ? CTL_00 : CTL_11;

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        return c == 2'b00 ? CTL_00 : c == 2'b01 ? CTL_01 : c == 2'b10 ? CTL_10 : CTL_11;
    endfunction

    logic [10:0] h, v, h_nxt, v_nxt, v_inc;
    logic        de, hs, vs, fs_q, de_q;
    logic [9:0]  ctl0, ctl1, ctl2, ctl0_q, ctl1_q, ctl2_q, t0, t1, t2;

    always_comb begin
        v_inc = v == V_LAST ? 11'd0 : v + 11'd1;
        h_nxt = h == H_LAST ? 11'd0 : h + 11'd1;
        v_nxt = h == H_LAST ? v_inc : v;
        de    = (h < H_ACT_L) && (v < V_ACT_L);
        hs    = (h >= HS_BEG && h < HS_END) ? SYNC_POL : !SYNC_POL;
        vs    = (v >= VS_BEG && v < VS_END) ? SYNC_POL : !SYNC_POL;
    end

`ifdef TMDS_SEQ_HDMI_GUARD_EN
    localparam logic [10:0] PRE_BEG = 11'(H_TOT - 10);
    localparam logic [10:0] GB_BEG  = 11'(H_TOT - 2);
    localparam logic [9:0]  GB_0    = 10'b1011001100;
    localparam logic [9:0]  GB_1    = 10'b0100110011;
    logic pre, gb;
    // Preamble and guard band lead into every line whose successor carries video.
    always_comb begin
        pre  = (v_inc < V_ACT_L) && h >= PRE_BEG && h < GB_BEG;
        gb   = (v_inc < V_ACT_L) && h >= GB_BEG;
        ctl0 = gb ? GB_0 : ctl_sym({vs, hs});
        ctl1 = gb ? GB_1 : pre ? CTL_01 : CTL_00;
        ctl2 = gb ? GB_0 : CTL_00;
    end
`else
    always_comb begin
        ctl0 = ctl_sym({vs, hs});
        ctl1 = CTL_00;
        ctl2 = CTL_00;
    end
`endif

    // Stage 1 lines control decisions up with enc_q; stage 2 picks the final symbol.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h      <= 11'd0;
            v      <= V_ACT_L;
            fs_q   <= 1'b0;
            de_q   <= 1'b0;
            ctl0_q <= BLANK0;
            ctl1_q <= CTL_00;
            ctl2_q <= CTL_00;
            t0     <= BLANK0;
            t1     <= CTL_00;
            t2     <= CTL_00;
        end else begin
            h      <= h_nxt;
            v      <= v_nxt;
            fs_q   <= h_nxt == 11'd0 && v_nxt == 11'd0;
            de_q   <= de;
            ctl0_q <= ctl0;
            ctl1_q <= ctl1;
            ctl2_q <= ctl2;
            t0     <= de_q ? bus.enc_q0 : ctl0_q;
            t1     <= de_q ? bus.enc_q1 : ctl1_q;
            t2     <= de_q ? bus.enc_q2 : ctl2_q;
        end
    end

    assign bus.pix_rdy     = de;
    assign bus.x           = h;
    assign bus.y           = v;
    assign bus.frame_start = fs_q;
    assign bus.enc_din0    = de ? bus.pix_b : 8'h00;
    assign bus.enc_din1    = de ? bus.pix_g : 8'h00;
    assign bus.enc_din2    = de ? bus.pix_r : 8'h00;
    assign bus.tmds0       = t0;
    assign bus.tmds1       = t1;
    assign bus.tmds2       = t2;
endmodule
